melody_player: RTL and testbench

// - Parametrised successor of the fixed 7-note buzzer driver. Plays a sequence of note codes from a

---
 rtl/melody_pkg.sv | 35 +++
 rtl/tone_gen.sv | 46 ++++
 rtl/melody_player.sv | 142 ++++++++++++++
 tb/tb_melody_player.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/melody_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the melody player: note codes, FSM states, the 50 MHz
// tone-period table and the helper that turns a note code into a shifted period.
package melody_pkg;

    localparam int PERIOD_W = 18;

    localparam logic [3:0] REST = 4'd0;
    localparam logic [3:0] DO   = 4'd1;
    localparam logic [3:0] RE   = 4'd2;
    localparam logic [3:0] MI   = 4'd3;
    localparam logic [3:0] FA   = 4'd4;
    localparam logic [3:0] SO   = 4'd5;
    localparam logic [3:0] LA   = 4'd6;
    localparam logic [3:0] TI   = 4'd7;

    // Entry 0 is the rest; a zero period keeps the PWM low for the whole slot.
    localparam logic [PERIOD_W-1:0] TONE_PERIOD [8] = '{
        18'd0, 18'd190_840, 18'd170_068, 18'd151_515,
        18'd143_266, 18'd127_551, 18'd113_636, 18'd101_214
    };

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_e;

    function automatic logic [PERIOD_W-1:0] period_of(input logic [3:0]  code,
                                                       input int unsigned shift);
        logic [PERIOD_W-1:0] p;
        p = (code <= TI) ? TONE_PERIOD[code[2:0]] : '0;
        return (shift >= PERIOD_W) ? '0 : (p >> shift);
    endfunction

endpackage

// File: rtl/tone_gen.sv
`timescale 1ns/1ps
// Square-wave tone generator: free-running counter over 0..period-1 with a
// registered PWM compare against high_cnt.
module tone_gen
    import melody_pkg::*;
(
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                restart,
    input  logic [PERIOD_W-1:0] period,
    input  logic [PERIOD_W-1:0] high_cnt,
    input  logic                en,
    output logic                pwm
);

    localparam logic [PERIOD_W:0] ONE_W = 1;

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W:0]   cnt_inc;
    logic                pwm_q, pwm_d;

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_inc = {1'b0, cnt_q} + ONE_W;
        cnt_d   = cnt_inc[PERIOD_W-1:0];
        pwm_d   = en && (cnt_q < high_cnt);
        // Extra bit in the compare keeps P=0 and P=1 pinned at count 0.
        if (restart || (cnt_inc >= {1'b0, period})) begin
            cnt_d = '0;
        end
    end

    // NOTE: sequential state uses <= so all flops sample the pre-edge values together.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/melody_player.sv
`timescale 1ns/1ps
// Parametrised melody player: steps through packed note codes, one slot every
// NOTE_CYCLES clocks, driving a PWM buzzer with runtime octave and volume.
module melody_player
    import melody_pkg::*;
#(
    parameter int unsigned NOTE_CYCLES  = 25_000_000,
    parameter int unsigned SEQ_LEN      = 7,
    parameter logic [63:0] SEQ          = 64'h0000_0000_0765_4321,
    parameter int unsigned PERIOD_SHIFT = 0
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       start,
    input  logic       stop,
    input  logic       loop_en,
    input  logic [1:0] octave,
    input  logic [1:0] volume,
    output logic       busy,
    output logic [3:0] note_idx,
    output logic       done,
    output logic       out
);

    localparam logic [25:0]         LAST_CNT   = 26'(NOTE_CYCLES - 1);
    localparam logic [3:0]          LAST_IDX   = 4'(SEQ_LEN - 1);
    localparam logic [PERIOD_W-1:0] MIN_PERIOD = 2;

    state_e              state_q, state_d;
    logic [25:0]         note_cnt_q, note_cnt_d;
    logic [3:0]          idx_q, idx_d;
    logic                done_q, done_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] high_q, high_d;
    logic                mute_q, mute_d;
    logic                slot_load;
    logic [3:0]          next_code;
    logic [PERIOD_W-1:0] next_period;
    logic                tone_en;
    logic                tone_restart;
    logic                pwm;

    // FSM, note timer and slot index.
    always_comb begin
        state_d    = state_q;
        note_cnt_d = note_cnt_q;
        idx_d      = idx_q;
        done_d     = 1'b0;
        slot_load  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d    = S_PLAY;
                    note_cnt_d = '0;
                    idx_d      = '0;
                    slot_load  = 1'b1;
                end
            end
            S_PLAY: begin
                if (stop) begin
                    state_d    = S_IDLE;
                    note_cnt_d = '0;
                    idx_d      = '0;
                end else if (note_cnt_q == LAST_CNT) begin
                    note_cnt_d = '0;
                    if (idx_q < LAST_IDX) begin
                        idx_d     = idx_q + 4'd1;
                        slot_load = 1'b1;
                    end else if (loop_en) begin
                        idx_d     = '0;
                        slot_load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end
                end else begin
                    note_cnt_d = note_cnt_q + 26'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Octave and volume are captured only when a slot starts, so mid-note changes wait for the boundary.
    always_comb begin
        next_code   = SEQ[{idx_d, 2'b00} +: 4];
        next_period = period_of(next_code, PERIOD_SHIFT + 32'(octave));
        period_d    = period_q;
        high_d      = high_q;
        mute_d      = mute_q;
        if (state_d == S_IDLE) begin
            period_d = '0;
            high_d   = '0;
            mute_d   = 1'b0;
        end else if (slot_load) begin
            period_d = next_period;
            high_d   = (next_period >> 1) >> volume;
            mute_d   = (next_code == REST) || (volume == 2'd3) || (next_period < MIN_PERIOD);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            note_cnt_q <= '0;
            idx_q      <= '0;
            done_q     <= 1'b0;
            period_q   <= '0;
            high_q     <= '0;
            mute_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            note_cnt_q <= note_cnt_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
            period_q   <= period_d;
            high_q     <= high_d;
            mute_q     <= mute_d;
        end
    end

    // Gating with the next state drops the pin on the same edge that leaves PLAY.
    assign tone_en      = (state_q == S_PLAY) && (state_d == S_PLAY) && !mute_q;
    assign tone_restart = slot_load || (state_d == S_IDLE);

    tone_gen u_tone (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .restart  (tone_restart),
        .period   (period_q),
        .high_cnt (high_q),
        .en       (tone_en),
        .pwm      (pwm)
    );

    assign busy     = (state_q == S_PLAY);
    assign note_idx = idx_q;
    assign done     = done_q;
    assign out      = pwm;

endmodule

// File: tb/tb_melody_player.sv
`timescale 1ns/1ps
// Bench for melody_player: expected slots are queued when playback is started and
// compared cycle by cycle as the player runs through them.
module tb_melody_player;

    localparam int NOTE  = 400;
    localparam int SHIFT = 10;
    localparam int TONE [8] = '{0, 190840, 170068, 151515, 143266, 127551, 113636, 101214};

    typedef struct {
        int idx;
        int p;
        int h;
        bit silent;
        bit last;
    } slot_t;

    logic       sys_clk, sys_rst;
    logic       start, stop, loop_en;
    logic [1:0] octave, volume;
    logic       busy, done, out;
    logic [3:0] note_idx;
    logic       start_r, stop_r;
    logic       busy_r, done_r, out_r;
    logic [3:0] note_idx_r;

    logic       sel;
    logic       m_busy, m_done, m_out;
    logic [3:0] m_idx;

    slot_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    melody_player #(
        .NOTE_CYCLES (NOTE),
        .SEQ_LEN     (7),
        .SEQ         (64'h0000_0000_0765_4321),
        .PERIOD_SHIFT(SHIFT)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .start   (start),
        .stop    (stop),
        .loop_en (loop_en),
        .octave  (octave),
        .volume  (volume),
        .busy    (busy),
        .note_idx(note_idx),
        .done    (done),
        .out     (out)
    );

    melody_player #(
        .NOTE_CYCLES (NOTE),
        .SEQ_LEN     (3),
        .SEQ         (64'h0000_0000_0000_0301),
        .PERIOD_SHIFT(SHIFT)
    ) dut_rest (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .start   (start_r),
        .stop    (stop_r),
        .loop_en (loop_en),
        .octave  (octave),
        .volume  (volume),
        .busy    (busy_r),
        .note_idx(note_idx_r),
        .done    (done_r),
        .out     (out_r)
    );

    assign m_busy = sel ? busy_r     : busy;
    assign m_done = sel ? done_r     : done;
    assign m_out  = sel ? out_r      : out;
    assign m_idx  = sel ? note_idx_r : note_idx;

    initial begin
        sys_clk = 1'b0;
        forever #10 sys_clk = ~sys_clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_start(input logic v);
        if (sel) start_r = v;
        else     start   = v;
    endtask

    task automatic pulse_start();
        drive_start(1'b1);
        @(negedge sys_clk);
        drive_start(1'b0);
    endtask

    task automatic push_slot(input int code, input int idx, input int oct, input int vol, input bit last);
        slot_t s;
        s.idx    = idx;
        s.p      = TONE[code] >> (SHIFT + oct);
        s.h      = (s.p >> 1) >> vol;
        s.silent = (code == 0) || (vol == 3) || (s.p < 2);
        s.last   = last;
        exp_q.push_back(s);
    endtask

    // Entered at the negedge where the slot's note timer reads 0; leaves ncyc cycles later.
    task automatic check_slot(input int ncyc, input int poke_at);
        slot_t e;
        int    ctl_bad, out_bad, hi_first;
        logic  exp_o;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 1, 0);
            return;
        end
        e        = exp_q.pop_front();
        ctl_bad  = 0;
        out_bad  = 0;
        hi_first = 0;
        for (int m = 0; m < ncyc; m++) begin
            if (m_idx !== 4'(e.idx) || m_busy !== 1'b1 || m_done !== 1'b0) ctl_bad++;
            drive_start(m == poke_at);
            @(negedge sys_clk);
            drive_start(1'b0);
            if (e.silent || (e.last && m == NOTE - 1)) exp_o = 1'b0;
            else                                        exp_o = ((m % e.p) < e.h);
            if (m_out !== exp_o) out_bad++;
            if (m < e.p && m_out === 1'b1) hi_first++;
        end
        check($sformatf("slot%0d_ctl", e.idx), ctl_bad, 0);
        check($sformatf("slot%0d_out", e.idx), out_bad, 0);
        if (ncyc >= e.p) check($sformatf("slot%0d_high", e.idx), hi_first, e.silent ? 0 : e.h);
    endtask

    task automatic expect_done(input string tag);
        check({tag, "_done"}, m_done, 1);
        check({tag, "_busy"}, m_busy, 0);
        check({tag, "_out"},  m_out,  0);
        check({tag, "_idx"},  m_idx,  0);
        @(negedge sys_clk);
        check({tag, "_done_1cyc"}, m_done, 0);
    endtask

    initial begin
        int bad;
        sys_rst = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        loop_en = 1'b0;
        octave  = 2'd0;
        volume  = 2'd0;
        start_r = 1'b0;
        stop_r  = 1'b0;
        sel     = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("rst_busy", busy, 0);
        check("rst_idx", note_idx, 0);
        check("rst_done", done, 0);
        check("rst_out", out, 0);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // One-shot pass, full volume, base octave.
        for (int i = 0; i < 7; i++) push_slot(i + 1, i, 0, 0, i == 6);
        pulse_start();
        repeat (7) check_slot(NOTE, -1);
        expect_done("oneshot");

        // Loop twice, dropping loop_en during the final slot of the second pass.
        loop_en = 1'b1;
        for (int i = 0; i < 7; i++) push_slot(i + 1, i, 0, 0, 1'b0);
        for (int i = 0; i < 7; i++) push_slot(i + 1, i, 0, 0, i == 6);
        pulse_start();
        repeat (13) check_slot(NOTE, -1);
        loop_en = 1'b0;
        check_slot(NOTE, -1);
        expect_done("loop");

        // Volume 1, volume 3 (mute) and octave 1 passes.
        for (int cfg = 0; cfg < 3; cfg++) begin
            octave = (cfg == 2) ? 2'd1 : 2'd0;
            volume = (cfg == 0) ? 2'd1 : (cfg == 1) ? 2'd3 : 2'd0;
            for (int i = 0; i < 7; i++) push_slot(i + 1, i, int'(octave), int'(volume), i == 6);
            pulse_start();
            repeat (7) check_slot(NOTE, -1);
            expect_done($sformatf("cfg%0d", cfg));
        end
        octave = 2'd0;
        volume = 2'd0;

        // Volume changed during slot 0 takes effect from slot 1.
        push_slot(1, 0, 0, 0, 1'b0);
        for (int i = 1; i < 7; i++) push_slot(i + 1, i, 0, 1, i == 6);
        pulse_start();
        volume = 2'd1;
        repeat (7) check_slot(NOTE, -1);
        expect_done("volmid");
        volume = 2'd0;

        // Start while busy is ignored; stop at cycle 150 of slot 2 aborts.
        for (int i = 0; i < 3; i++) push_slot(i + 1, i, 0, 0, 1'b0);
        pulse_start();
        check_slot(NOTE, -1);
        check_slot(NOTE, 200);
        check_slot(150, -1);
        stop = 1'b1;
        @(negedge sys_clk);
        stop = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_out", out, 0);
        check("stop_idx", note_idx, 0);
        check("stop_done", done, 0);
        bad = 0;
        repeat (20) begin
            @(negedge sys_clk);
            if (busy !== 1'b0 || done !== 1'b0 || out !== 1'b0) bad++;
        end
        check("stop_stays_idle", bad, 0);

        // Start and stop together from IDLE: stop wins.
        start = 1'b1;
        stop  = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        stop  = 1'b0;
        bad   = 0;
        repeat (5) begin
            if (busy !== 1'b0 || note_idx !== 4'd0) bad++;
            @(negedge sys_clk);
        end
        check("start_stop_idle", bad, 0);

        // Asynchronous reset in the middle of slot 3 while the pin is high.
        for (int i = 0; i < 4; i++) push_slot(i + 1, i, 0, 0, 1'b0);
        pulse_start();
        repeat (3) check_slot(NOTE, -1);
        check_slot(50, -1);
        check("pre_rst_out", out, 1);
        #3 sys_rst = 1'b1;
        #1;
        check("arst_out", out, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_idx", note_idx, 0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge sys_clk);
            if (busy !== 1'b0 || out !== 1'b0) bad++;
        end
        check("post_rst_idle", bad, 0);
        push_slot(1, 0, 0, 0, 1'b0);
        pulse_start();
        check_slot(NOTE, -1);
        stop = 1'b1;
        @(negedge sys_clk);
        stop = 1'b0;
        check("restart_stop_busy", busy, 0);

        // Rest slot between Do and Mi on the second player.
        sel = 1'b1;
        push_slot(1, 0, 0, 0, 1'b0);
        push_slot(0, 1, 0, 0, 1'b0);
        push_slot(3, 2, 0, 0, 1'b1);
        pulse_start();
        repeat (3) check_slot(NOTE, -1);
        expect_done("rest");
        sel = 1'b0;

        check("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
